// File: rtl/fp_multicycle_ctrl.sv
// Multi-cycle FP sequencer for the RV32IF execute stage: freezes the front end for
// the operation's latency, then releases it into MEM with a result strobe.
module fp_multicycle_ctrl #(
  parameter int FADD_LAT  = 3,
  parameter int FMUL_LAT  = 4,
  parameter int FDIV_LAT  = 16,
  parameter int FSQRT_LAT = 20,
  parameter int CNT_W     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startE,
  input  logic [1:0]  opClassE,
  input  logic [4:0]  RdE,
  input  logic        FlushE,
  input  logic        statClr,
  output logic        fpuStart,
  output logic [1:0]  fpuOp,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        BubbleM,
  output logic        resultValid,
  output logic [4:0]  resultRd,
  output logic        busy,
  output logic [31:0] stallCount
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      stall_cnt;
  logic             accept;
  logic             stall;

  // Loaded count is LAT-1: the accept cycle itself is the first stalled cycle.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [1:0] op);
    case (op)
      2'b00:   lat_m1 = CNT_W'(FADD_LAT - 1);
      2'b01:   lat_m1 = CNT_W'(FMUL_LAT - 1);
      2'b10:   lat_m1 = CNT_W'(FDIV_LAT - 1);
      default: lat_m1 = CNT_W'(FSQRT_LAT - 1);
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign accept = (state == IDLE) && startE && !FlushE;
  assign stall  = accept || (state == BUSY);

  assign fpuStart    = accept;
  assign StallF      = stall;
  assign StallD      = stall;
  assign StallE      = stall;
  assign BubbleM     = stall;
  assign resultValid = (state == DONE);
  assign busy        = (state != IDLE);
  assign stallCount  = stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      fpuOp    <= 2'b00;
      resultRd <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= lat_m1(opClassE);
            fpuOp    <= opClassE;
            resultRd <= RdE;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // startE still shows the completing instruction here, so it is not sampled.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (statClr) begin
      stall_cnt <= 32'd0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_fp_multicycle_ctrl.sv
// Scoreboard bench for fp_multicycle_ctrl: directed scenarios plus random traffic,
// checked against a cycle-window reference model.
module tb_fp_multicycle_ctrl;

  localparam int FADD_LAT  = 3;
  localparam int FMUL_LAT  = 4;
  localparam int FDIV_LAT  = 16;
  localparam int FSQRT_LAT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        startE;
  logic [1:0]  opClassE;
  logic [4:0]  RdE;
  logic        FlushE;
  logic        statClr;
  logic        fpuStart;
  logic [1:0]  fpuOp;
  logic        StallF, StallD, StallE, BubbleM;
  logic        resultValid;
  logic [4:0]  resultRd;
  logic        busy;
  logic [31:0] stallCount;

  fp_multicycle_ctrl #(
    .FADD_LAT(FADD_LAT), .FMUL_LAT(FMUL_LAT), .FDIV_LAT(FDIV_LAT),
    .FSQRT_LAT(FSQRT_LAT), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset), .startE(startE), .opClassE(opClassE), .RdE(RdE),
    .FlushE(FlushE), .statClr(statClr), .fpuStart(fpuStart), .fpuOp(fpuOp),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .BubbleM(BubbleM),
    .resultValid(resultValid), .resultRd(resultRd), .busy(busy),
    .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         done;
    logic [4:0] rd;
    logic [1:0] op;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          acc_t    = -1000;
  int          acc_l    = 0;
  int          free_at  = 0;
  int          starts   = 0;
  logic [31:0] sc_exp   = 32'd0;
  bit          in_reset = 1'b1;
  bit          done_all = 1'b0;

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b00:   return FADD_LAT;
      2'b01:   return FMUL_LAT;
      2'b10:   return FDIV_LAT;
      default: return FSQRT_LAT;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus; an op the model accepts is queued with its completion cycle.
  task automatic step(input bit s, input logic [1:0] op, input logic [4:0] rd,
                      input bit fl, input bit clr);
    @(posedge clk);
    #1;
    startE = s; opClassE = op; RdE = rd; FlushE = fl; statClr = clr;
    if (s && !fl && cyc >= free_at) begin
      acc_t   = cyc;
      acc_l   = lat_of(op);
      free_at = cyc + acc_l + 1;
      q.push_back('{cyc + acc_l, rd, op});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    in_reset = 1'b1;
    reset    = 1'b1;
    #1;
    chk("rst_stallF", 32'(StallF), 32'd0);
    chk("rst_bubbleM", 32'(BubbleM), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resultValid", 32'(resultValid), 32'd0);
    chk("rst_stallCount", stallCount, 32'd0);
    chk("rst_fpuOp", 32'(fpuOp), 32'd0);
    chk("rst_resultRd", 32'(resultRd), 32'd0);
    q.delete();
    acc_t = -1000; free_at = 0; sc_exp = 32'd0;
    startE = 1'b0; FlushE = 1'b0; statClr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_reset = 1'b0;
  endtask

  // Monitor: compares every output once per cycle on the falling edge.
  initial begin
    bit exp_stall, exp_start, exp_busy, exp_rv;
    forever begin
      @(negedge clk);
      if (!in_reset && !done_all) begin
        exp_stall = (cyc >= acc_t) && (cyc <= acc_t + acc_l - 1);
        exp_start = (cyc == acc_t);
        exp_busy  = (cyc > acc_t) && (cyc <= acc_t + acc_l);
        if (q.size() > 0 && q[0].done < cyc) begin
          chk("missing_resultValid", 32'(q[0].done), 32'(cyc));
          void'(q.pop_front());
        end
        exp_rv = (q.size() > 0) && (q[0].done == cyc);
        chk("StallF", 32'(StallF), 32'(exp_stall));
        chk("StallD", 32'(StallD), 32'(exp_stall));
        chk("StallE", 32'(StallE), 32'(exp_stall));
        chk("BubbleM", 32'(BubbleM), 32'(exp_stall));
        chk("fpuStart", 32'(fpuStart), 32'(exp_start));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("resultValid", 32'(resultValid), 32'(exp_rv));
        chk("stallCount", stallCount, sc_exp);
        if (fpuStart) starts++;
        if (resultValid && exp_rv) begin
          chk("resultRd", 32'(resultRd), 32'(q[0].rd));
          chk("fpuOp", 32'(fpuOp), 32'(q[0].op));
          void'(q.pop_front());
        end
        if (statClr) sc_exp = 32'd0;
        else if (exp_stall && sc_exp != 32'hFFFF_FFFF) sc_exp = sc_exp + 32'd1;
      end
    end
  end

  initial begin
    int s0;
    reset = 1'b1; startE = 1'b0; opClassE = 2'b00; RdE = 5'd0; FlushE = 1'b0; statClr = 1'b0;
    #2;
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_stallCount", stallCount, 32'd0);
    chk("init_fpuOp", 32'(fpuOp), 32'd0);
    chk("init_resultRd", 32'(resultRd), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; in_reset = 1'b0;

    // fadd to rd 5
    step(1'b1, 2'b00, 5'd5, 1'b0, 1'b0);
    idle(5);
    chk("fadd_stallCount", stallCount, 32'd3);

    // fdiv then fsqrt back-to-back, startE held high throughout
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b1);
    s0 = starts;
    step(1'b1, 2'b10, 5'd7, 1'b0, 1'b0);
    for (int i = 1; i < 17; i++) step(1'b1, 2'b10, 5'd7, 1'b0, 1'b0);
    step(1'b1, 2'b11, 5'd8, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 2'b11, 5'd8, 1'b0, 1'b0);
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
    idle(2);
    chk("divsqrt_stallCount", stallCount, 32'd36);
    chk("divsqrt_starts", 32'(starts - s0), 32'd2);

    // flush with start while idle
    step(1'b1, 2'b01, 5'd3, 1'b1, 1'b0);
    idle(2);

    // fmul, with flush and changed operands two cycles in
    step(1'b1, 2'b01, 5'd9, 1'b0, 1'b0);
    step(1'b1, 2'b01, 5'd9, 1'b0, 1'b0);
    step(1'b1, 2'b11, 5'd20, 1'b1, 1'b0);
    step(1'b0, 2'b10, 5'd21, 1'b1, 1'b0);
    idle(3);

    // reset in the middle of an fdiv, then a clean fadd
    step(1'b1, 2'b10, 5'd11, 1'b0, 1'b0);
    idle(6);
    async_reset();
    step(1'b1, 2'b00, 5'd12, 1'b0, 1'b0);
    idle(5);

    // saturation, then clear winning over a simultaneous stall
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
    dut.stall_cnt = 32'hFFFF_FFFE;
    sc_exp = 32'hFFFF_FFFE;
    step(1'b1, 2'b00, 5'd13, 1'b0, 1'b0);
    idle(5);
    chk("sat_stallCount", stallCount, 32'hFFFF_FFFF);
    step(1'b1, 2'b00, 5'd14, 1'b0, 1'b1);
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
    chk("clr_wins", stallCount, 32'd0);
    idle(4);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 3) != 0, 2'($urandom), 5'($urandom),
           ($urandom % 6) == 0, ($urandom % 60) == 0);
    end
    idle(30);
    chk("queue_drained", 32'(q.size()), 32'd0);
    done_all = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
